line_scheduler: RTL and testbench

Round-robin phase controller for the four-line signal display. It sequences line_0..line_3 one at a time through green, amber and all-red clearance phases, loading each line's BCD green time from a0..a3. It counts the phase down in BCD on a 1 Hz strobe and drives D_OUT1/D_OUT0 for the seven-segment/VGA countdown readout. It replaces free-running line selection with a single owner of the shared countdown datapath.

---
 rtl/line_scheduler.sv | 175 +++++++++++++++++
 tb/tb_line_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/line_scheduler.sv
// line_scheduler: round-robin green/amber/clear sequencer with BCD countdown; AMBER_PHASE_EN enables amber.
// Latency: one C_CLK edge per transition, IDLE->GREEN one edge after C_EN; D_OUT updates on that edge.
// Backpressure: none; C_EN low freezes state, counter and outputs and ignores TICK.
module line_scheduler #(
    parameter logic [3:0] AMBER_SECS = 4'd3,
    parameter logic [3:0] CLEAR_SECS = 4'd1
) (
    input  logic       C_CLK,
    input  logic       RST,
    input  logic       C_EN,
    input  logic       TICK,
    input  logic [7:0] a0,
    input  logic [7:0] a1,
    input  logic [7:0] a2,
    input  logic [7:0] a3,
    output logic       line_0,
    output logic       line_1,
    output logic       line_2,
    output logic       line_3,
    output logic       amber,
    output logic       all_red,
    output logic [3:0] D_OUT1,
    output logic [3:0] D_OUT0,
    output logic [1:0] cur_line,
    output logic       phase_done
);

    typedef enum logic [1:0] {IDLE, GREEN, AMBER, CLEAR} state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [1:0] line_q, line_nxt;
    logic       done_nxt;

    logic [7:0] dur [4];
    logic [3:0] nz;
    logic       first_vld, rr_vld;
    logic [1:0] first_idx, rr_idx, probe;
    logic       cnt_end;

    function automatic logic [7:0] sanitize(input logic [7:0] v);
        return {(v[7:4] > 4'd9) ? 4'd9 : v[7:4], (v[3:0] > 4'd9) ? 4'd9 : v[3:0]};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    always_comb begin
        dur[0] = a0;
        dur[1] = a1;
        dur[2] = a2;
        dur[3] = a3;
        for (int i = 0; i < 4; i++)
            nz[i] = |dur[i];
    end

    // Descending scans so the lowest index / smallest round-robin offset wins.
    always_comb begin
        first_vld = 1'b0;
        first_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (nz[i]) begin
                first_vld = 1'b1;
                first_idx = 2'(i);
            end
        end
        rr_vld = 1'b0;
        rr_idx = line_q;
        probe  = line_q;
        for (int k = 4; k >= 1; k--) begin
            probe = line_q + 2'(k);
            if (nz[probe]) begin
                rr_vld = 1'b1;
                rr_idx = probe;
            end
        end
    end

    assign cnt_end = (cnt <= 8'h01);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        line_nxt  = line_q;
        done_nxt  = 1'b0;
        if (C_EN) begin
            case (state)
                IDLE: begin
                    if (first_vld) begin
                        state_nxt = GREEN;
                        cnt_nxt   = sanitize(dur[first_idx]);
                        line_nxt  = first_idx;
                    end
                end
                GREEN: begin
                    if (TICK) begin
                        if (cnt_end) begin
`ifdef AMBER_PHASE_EN
                            state_nxt = AMBER;
                            cnt_nxt   = {4'h0, AMBER_SECS};
`else
                            state_nxt = CLEAR;
                            cnt_nxt   = {4'h0, CLEAR_SECS};
`endif
                        end else begin
                            cnt_nxt = bcd_dec(cnt);
                        end
                    end
                end
                AMBER: begin
                    if (TICK) begin
                        if (cnt_end) begin
                            state_nxt = CLEAR;
                            cnt_nxt   = {4'h0, CLEAR_SECS};
                        end else begin
                            cnt_nxt = bcd_dec(cnt);
                        end
                    end
                end
                CLEAR: begin
                    if (TICK) begin
                        if (cnt_end) begin
                            done_nxt = 1'b1;
                            if (rr_vld) begin
                                state_nxt = GREEN;
                                cnt_nxt   = sanitize(dur[rr_idx]);
                                line_nxt  = rr_idx;
                            end else begin
                                state_nxt = IDLE;
                                cnt_nxt   = 8'h00;
                            end
                        end else begin
                            cnt_nxt = bcd_dec(cnt);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge C_CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            cnt        <= 8'h00;
            line_q     <= 2'd0;
            phase_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            line_q     <= line_nxt;
            phase_done <= done_nxt;
        end
    end

    logic line_on;
    assign line_on  = (state == GREEN) || (state == AMBER);
    assign line_0   = line_on && (line_q == 2'd0);
    assign line_1   = line_on && (line_q == 2'd1);
    assign line_2   = line_on && (line_q == 2'd2);
    assign line_3   = line_on && (line_q == 2'd3);
    assign all_red  = (state == IDLE) || (state == CLEAR);
    assign D_OUT1   = cnt[7:4];
    assign D_OUT0   = cnt[3:0];
    assign cur_line = line_q;
`ifdef AMBER_PHASE_EN
    assign amber    = (state == AMBER);
`else
    assign amber    = 1'b0;
`endif

endmodule

// File: tb/tb_line_scheduler.sv
// Bench for line_scheduler: directed scenarios plus random traffic against a seconds-level reference model.
module tb_line_scheduler;

`ifdef AMBER_PHASE_EN
    localparam bit AMBER_EN = 1'b1;
`else
    localparam bit AMBER_EN = 1'b0;
`endif
    localparam int P_IDLE = 0, P_GREEN = 1, P_AMBER = 2, P_CLEAR = 3;
    localparam int AMBER_S = 3, CLEAR_S = 1;

    logic       C_CLK = 1'b0;
    logic       RST, C_EN, TICK;
    logic [7:0] av [4];
    logic       line_0, line_1, line_2, line_3, amber, all_red, phase_done;
    logic [3:0] D_OUT1, D_OUT0;
    logic [1:0] cur_line;

    line_scheduler #(.AMBER_SECS(4'd3), .CLEAR_SECS(4'd1)) dut (
        .C_CLK(C_CLK), .RST(RST), .C_EN(C_EN), .TICK(TICK),
        .a0(av[0]), .a1(av[1]), .a2(av[2]), .a3(av[3]),
        .line_0(line_0), .line_1(line_1), .line_2(line_2), .line_3(line_3),
        .amber(amber), .all_red(all_red), .D_OUT1(D_OUT1), .D_OUT0(D_OUT0),
        .cur_line(cur_line), .phase_done(phase_done)
    );

    always #5 C_CLK = ~C_CLK;

    int    checks = 0;
    int    failures = 0;
    string tag = "init";

    int m_ph = P_IDLE, m_sec = 0, m_line = 0;
    bit m_done = 1'b0;
    bit dut_amber_seen = 1'b0, mdl_amber_seen = 1'b0;
    int l2_cnt = 0, pd_dut = 0, pd_mdl = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int san(input logic [7:0] v);
        int t = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        int o = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return t * 10 + o;
    endfunction

    function automatic logic [16:0] exp_vec();
        logic [3:0] ln = 4'b0;
        if (m_ph == P_GREEN || m_ph == P_AMBER) ln[m_line] = 1'b1;
        return {ln, m_ph == P_AMBER, m_ph == P_IDLE || m_ph == P_CLEAR,
                4'(m_sec / 10), 4'(m_sec % 10), 2'(m_line), m_done};
    endfunction

    function automatic logic [16:0] obs_vec();
        return {line_3, line_2, line_1, line_0, amber, all_red, D_OUT1, D_OUT0, cur_line, phase_done};
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_sec = 0; m_line = 0; m_done = 1'b0;
    endtask

    task automatic model_edge();
        m_done = 1'b0;
        if (!C_EN) return;
        if (m_ph == P_IDLE) begin
            for (int n = 0; n < 4; n++) begin
                if (av[n] != 8'h00) begin
                    m_ph = P_GREEN; m_line = n; m_sec = san(av[n]);
                    break;
                end
            end
        end else if (TICK) begin
            if (m_sec > 1) begin
                m_sec--;
            end else if (m_ph == P_GREEN) begin
                if (AMBER_EN) begin m_ph = P_AMBER; m_sec = AMBER_S; end
                else          begin m_ph = P_CLEAR; m_sec = CLEAR_S; end
            end else if (m_ph == P_AMBER) begin
                m_ph = P_CLEAR; m_sec = CLEAR_S;
            end else begin
                m_done = 1'b1;
                m_ph = P_IDLE; m_sec = 0;
                for (int k = 1; k <= 4; k++) begin
                    if (av[(m_line + k) % 4] != 8'h00) begin
                        m_line = (m_line + k) % 4;
                        m_ph = P_GREEN; m_sec = san(av[m_line]);
                        break;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge C_CLK);
        model_edge();
        #1;
        check(tag, obs_vec(), exp_vec());
        if (amber) dut_amber_seen = 1'b1;
        if (m_ph == P_AMBER) mdl_amber_seen = 1'b1;
        if (line_2) l2_cnt++;
        if (phase_done) pd_dut++;
        if (m_done) pd_mdl++;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #2;
        model_reset();
        check({tag, "_rst"}, obs_vec(), 17'h00800);
        RST = 1'b1;
    endtask

    task automatic tick_n(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            TICK = 1'b1; step();
            TICK = 1'b0;
            for (int g = 1; g < gap; g++) step();
        end
    endtask

    logic [7:0] borrow_seq [5];
    int         waited;

    initial begin
        RST = 1'b0; C_EN = 1'b0; TICK = 1'b0;
        for (int i = 0; i < 4; i++) av[i] = 8'h00;

        // Round-robin over 05,03,00,02 with a tick every 4 cycles.
        tag = "rr"; av[0] = 8'h05; av[1] = 8'h03; av[2] = 8'h00; av[3] = 8'h02;
        C_EN = 1'b1;
        do_reset();
        l2_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            TICK = (i % 4 == 3); step();
        end
        TICK = 1'b0;
        check("rr_line2_never", 32'(l2_cnt), 32'd0);

        // All durations zero: must idle through 100 ticks.
        tag = "zero"; for (int i = 0; i < 4; i++) av[i] = 8'h00;
        do_reset();
        tick_n(100, 4);
        check("zero_all_red", {31'b0, all_red}, 32'd1);

        // Tens borrow on line 1.
        tag = "borrow"; av[1] = 8'h12;
        do_reset();
        step();
        borrow_seq = '{8'h12, 8'h11, 8'h10, 8'h09, 8'h08};
        check("borrow_0", {24'b0, D_OUT1, D_OUT0}, {24'b0, borrow_seq[0]});
        for (int j = 1; j < 5; j++) begin
            tick_n(1, 2);
            check("borrow_seq", {24'b0, D_OUT1, D_OUT0}, {24'b0, borrow_seq[j]});
        end

        // Out-of-range digit clamp.
        tag = "clamp"; av[1] = 8'h00; av[0] = 8'h3C;
        do_reset();
        step();
        check("clamp_39", {24'b0, D_OUT1, D_OUT0}, 32'h39);

        // Pause mid-green, resume, then async reset mid-amber (mid-clear without amber).
        tag = "pause"; av[0] = 8'h09;
        do_reset();
        step();
        tick_n(2, 2);
        check("pause_pre", {24'b0, D_OUT1, D_OUT0}, 32'h07);
        C_EN = 1'b0;
        tick_n(10, 3);
        check("pause_hold", {24'b0, D_OUT1, D_OUT0}, 32'h07);
        C_EN = 1'b1;
        tick_n(1, 1);
        check("pause_resume", {24'b0, D_OUT1, D_OUT0}, 32'h06);
        waited = 0;
        while (!(AMBER_EN ? amber : all_red) && waited < 100) begin
            tick_n(1, 2); waited++;
        end
        check("pause_reach_phase", 32'(waited < 100), 32'd1);
        tag = "midphase";
        do_reset();
        step();

        // Single non-zero line re-enters itself after clear.
        tag = "single"; av[0] = 8'h00; av[2] = 8'h02;
        do_reset();
        pd_dut = 0; pd_mdl = 0;
        for (int i = 0; i < 60; i++) begin
            TICK = (i % 3 == 2); step();
        end
        TICK = 1'b0;
        check("single_pd_count", 32'(pd_dut), 32'(pd_mdl));

        // Random traffic: durations change, enable drops, occasional async reset.
        tag = "rand";
        for (int i = 0; i < 4; i++) av[i] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            TICK = ($urandom_range(0, 2) == 0);
            C_EN = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 199) == 0)
                av[$urandom_range(0, 3)] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 999) == 0) do_reset();
            step();
        end
        TICK = 1'b0;

        check("amber_presence", {31'b0, dut_amber_seen}, {31'b0, mdl_amber_seen});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
